ipg_tx_sched: RTL and testbench

IPG_TX_SCHED -- requirements
Module: ipg_tx_sched

---
 rtl/ipg_pkg.sv | 28 ++
 rtl/ipg_rr_arb.sv | 61 ++++++
 rtl/ipg_tx_sched.sv | 158 +++++++++++++++
 tb/tb_ipg_tx_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG transmit path: 64b/66b block-type codes,
// payload/chunk widths, the scheduler state encoding and a chunk-builder helper.
package ipg_pkg;

    // Width of one requester payload chunk and of the block handed to the PCS.
    localparam int IPG_PAYLOAD_W = 56;
    localparam int IPG_CHUNK_W   = 64;

    // 64b/66b block-type field values (first octet of a control block).
    localparam logic [7:0] BLOCK_TYPE_CTRL = 8'h1e;
    localparam logic [7:0] BLOCK_TYPE_S0   = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_T0   = 8'h87;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    // Wrap a payload into an all-control IPG block, payload in the upper bits.
    function automatic logic [IPG_CHUNK_W-1:0] make_ctrl_chunk(
        input logic [IPG_PAYLOAD_W-1:0] payload
    );
        return {payload, BLOCK_TYPE_CTRL};
    endfunction

endpackage

// File: rtl/ipg_rr_arb.sv
// Two-way message-level arbiter for the IPG scheduler.
// Grant is one-hot and purely combinational from the request vector; on a tie
// the favoured requester wins. The favour pointer flips to the requester that
// was not just served whenever ptr_upd pulses.
// Build option IPG_SCHED_STRICT_PRIO_EN: requester 0 always wins a tie and no
// pointer register exists.
module ipg_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       ptr_upd,
    input  logic       served_id,
    output logic [1:0] grant
);

    // Index of the requester that wins when both are requesting.
    logic ptr_fav;

`ifdef IPG_SCHED_STRICT_PRIO_EN
    // Fixed priority: requester 0 is always favoured.
    assign ptr_fav = 1'b0;

    logic unused_arb_inputs;
    assign unused_arb_inputs = &{1'b0, clk, rst_n, ptr_upd, served_id};
`else
    logic ptr_q;
    logic ptr_d;

    // Next favoured requester: the one not just served, else unchanged.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_upd) begin
            ptr_d = ~served_id;
        end
    end

    // Favour pointer register; requester 0 is favoured out of reset.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_fav = ptr_q;
`endif

    // One-hot grant: a lone requester wins outright, a tie goes to ptr_fav.
    // NOTE: a default is assigned first so every path drives grant and no
    // latch is inferred.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_fav ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ipg_tx_sched.sv
// IPG transmit scheduler: moves 56-bit chunks from two requesters into free
// inter-packet-gap slots as control blocks {payload, 8'h1e}.
// A message is granted in IDLE, streamed in XFER one chunk per free slot, and
// followed by MSG_GAP free slots left unused in GAP. Messages never interleave.
// A message without a last flag is cut at MAX_CHUNKS (1..15) and err_overlong
// latches until reset.
// Build option IPG_SCHED_STRICT_PRIO_EN: requester 0 always wins arbitration
// (handled inside ipg_rr_arb); all other behaviour is unchanged.
module ipg_tx_sched
    import ipg_pkg::*;
#(
    parameter int MAX_CHUNKS = 10,
    parameter int MSG_GAP    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     slot_avail,
    input  logic                     req0_valid,
    input  logic [IPG_PAYLOAD_W-1:0] req0_data,
    input  logic                     req0_last,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [IPG_PAYLOAD_W-1:0] req1_data,
    input  logic                     req1_last,
    output logic                     req1_ready,
    output logic                     ipg_valid,
    output logic [IPG_CHUNK_W-1:0]   ipg_chunk,
    output logic                     grant_id,
    output logic                     busy,
    output logic                     err_overlong
);

    localparam logic [3:0] CNT_LIMIT = 4'(MAX_CHUNKS);
    localparam int         GAP_W     = (MSG_GAP > 1) ? $clog2(MSG_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(MSG_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    sched_state_e             state_q, state_d;
    logic                     grant_id_q, grant_id_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     err_q, err_d;
    logic                     ipg_valid_q, ipg_valid_d;
    logic [IPG_CHUNK_W-1:0]   ipg_chunk_q, ipg_chunk_d;

    logic [1:0]               arb_grant;
    logic                     ptr_upd;
    logic                     own_valid;
    logic                     own_last;
    logic [IPG_PAYLOAD_W-1:0] own_data;
    logic [3:0]               cnt_inc;

    // Owner's request signals, selected by the latched grant.
    assign own_valid = grant_id_q ? req1_valid : req0_valid;
    assign own_last  = grant_id_q ? req1_last  : req0_last;
    assign own_data  = grant_id_q ? req1_data  : req0_data;
    assign cnt_inc   = cnt_q + 4'd1;

    ipg_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({req1_valid, req0_valid}),
        .ptr_upd   (ptr_upd),
        .served_id (grant_id_q),
        .grant     (arb_grant)
    );

    // Next-state, counters, output staging and combinational readys.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        err_d       = err_q;
        ipg_valid_d = 1'b0;
        ipg_chunk_d = ipg_chunk_q;
        ptr_upd     = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Grant is taken regardless of slot_avail; no chunk moves here.
                if (|arb_grant) begin
                    grant_id_d = arb_grant[1];
                    state_d    = ST_XFER;
                end
            end

            ST_XFER: begin
                req0_ready = slot_avail & ~grant_id_q;
                req1_ready = slot_avail &  grant_id_q;
                if (slot_avail && own_valid) begin
                    ipg_valid_d = 1'b1;
                    ipg_chunk_d = make_ctrl_chunk(own_data);
                    if (own_last || (cnt_inc == CNT_LIMIT)) begin
                        // Message ends: either properly or cut as overlong.
                        if (!own_last) begin
                            err_d = 1'b1;
                        end
                        ptr_upd = 1'b1;
                        cnt_d   = 4'd0;
                        if (MSG_GAP == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = GAP_INIT;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_GAP: begin
                // Burn MSG_GAP free slots; busy slots do not count.
                if (slot_avail) begin
                    gap_d = gap_q - GAP_ONE;
                    if (gap_q == GAP_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any message in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_id_q  <= 1'b0;
            cnt_q       <= 4'd0;
            gap_q       <= '0;
            err_q       <= 1'b0;
            ipg_valid_q <= 1'b0;
            ipg_chunk_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            ipg_valid_q <= ipg_valid_d;
            ipg_chunk_q <= ipg_chunk_d;
        end
    end

    assign ipg_valid    = ipg_valid_q;
    assign ipg_chunk    = ipg_chunk_q;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q != ST_IDLE);
    assign err_overlong = err_q;

endmodule

// File: tb/tb_ipg_tx_sched.sv
// Self-checking bench for ipg_tx_sched: a message-level behavioural model
// compared against the DUT every cycle, directed scenarios with literal
// expectations, and a randomized traffic phase.
`timescale 1ns/1ps
module tb_ipg_tx_sched;

    localparam int MAX_CHUNKS = 10;
    localparam int MSG_GAP    = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        slot_avail;
    logic        req0_valid, req0_last, req0_ready;
    logic [55:0] req0_data;
    logic        req1_valid, req1_last, req1_ready;
    logic [55:0] req1_data;
    logic        ipg_valid;
    logic [63:0] ipg_chunk;
    logic        grant_id, busy, err_overlong;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ipg_tx_sched #(.MAX_CHUNKS(MAX_CHUNKS), .MSG_GAP(MSG_GAP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .slot_avail   (slot_avail),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_last    (req0_last),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_last    (req1_last),
        .req1_ready   (req1_ready),
        .ipg_valid    (ipg_valid),
        .ipg_chunk    (ipg_chunk),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_overlong (err_overlong)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_xfer: a message is being streamed; m_gap: free slots still to skip.
    bit          m_xfer = 0, m_owner = 0, m_ptr = 0, m_err = 0, m_vld = 0;
    int          m_cnt = 0, m_gap = 0;
    logic [63:0] m_chunk = '0;
    bit          hs0 = 0, hs1 = 0;
    bit          e_r0, e_r1, o_valid, o_last;
    logic [55:0] o_data;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_xfer = 0; m_owner = 0; m_ptr = 0; m_err = 0; m_vld = 0;
            m_cnt = 0; m_gap = 0; m_chunk = '0;
        end
        e_r0 = m_xfer && !m_owner && slot_avail;
        e_r1 = m_xfer &&  m_owner && slot_avail;
        check("ready0",    req0_ready,   e_r0);
        check("ready1",    req1_ready,   e_r1);
        check("ipg_valid", ipg_valid,    m_vld);
        check("ipg_chunk", ipg_chunk,    m_chunk);
        check("busy",      busy,         m_xfer || (m_gap > 0));
        check("grant_id",  grant_id,     m_owner);
        check("err",       err_overlong, m_err);
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;

        if (rst_n) begin
            m_vld = 0;
            if (m_xfer) begin
                o_valid = m_owner ? req1_valid : req0_valid;
                o_last  = m_owner ? req1_last  : req0_last;
                o_data  = m_owner ? req1_data  : req0_data;
                if (slot_avail && o_valid) begin
                    m_vld   = 1;
                    m_chunk = {o_data, 8'h1e};
                    m_cnt++;
                    if (o_last || m_cnt == MAX_CHUNKS) begin
                        if (!o_last) m_err = 1;
                        m_ptr  = !m_owner;
                        m_cnt  = 0;
                        m_xfer = 0;
                        m_gap  = MSG_GAP;
                    end
                end
            end else if (m_gap > 0) begin
                if (slot_avail) m_gap--;
            end else if (req0_valid || req1_valid) begin
`ifdef IPG_SCHED_STRICT_PRIO_EN
                m_owner = !req0_valid;
`else
                m_owner = (req0_valid && req1_valid) ? m_ptr : !req0_valid;
`endif
                m_xfer = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slot_avail = 0;
        req0_valid = 0; req0_data = '0; req0_last = 0;
        req1_valid = 0; req1_data = '0; req1_last = 0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
    endtask

    bit          seq[$];
    bit          exp_seq[4];
    int          n, got;
    int          s_len[2], s_idx[2];
    logic [55:0] s_data[2];
    bit          hs[2];

    initial begin
        idle_inputs();
        #1 rst_n = 0;
        req0_valid = 1; req1_valid = 1; slot_avail = 1;
        #2;
        check("rst_ipg_valid", ipg_valid, 0);
        check("rst_ipg_chunk", ipg_chunk, 0);
        check("rst_busy",      busy, 0);
        check("rst_grant",     grant_id, 0);
        check("rst_err",       err_overlong, 0);
        check("rst_ready0",    req0_ready, 0);
        check("rst_ready1",    req1_ready, 0);
        tick();
        tick();
        idle_inputs();
        rst_n = 1;

        // --- 3-chunk message from requester 0 ---
        req0_valid = 1; req0_data = 56'hA1; req0_last = 0; slot_avail = 1;
        #1 check("a_ready_idle", req0_ready, 0);
        tick();
        #1 check("a_ready_xfer", req0_ready, 1);
        check("a_grant", grant_id, 0);
        tick();
        check("a_vld1", ipg_valid, 1);
        check("a_chunk1", ipg_chunk, {56'hA1, 8'h1e});
        req0_data = 56'hA2;
        tick();
        check("a_chunk2", ipg_chunk, {56'hA2, 8'h1e});
        req0_data = 56'hA3; req0_last = 1;
        tick();
        check("a_chunk3", ipg_chunk, {56'hA3, 8'h1e});
        check("a_busy_gap", busy, 1);
        req0_valid = 0; req0_last = 0;
        #1 check("a_ready_gap", req0_ready, 0);
        tick();
        check("a_idle", busy, 0);
        check("a_no_vld", ipg_valid, 0);
        check("a_hold", ipg_chunk, {56'hA3, 8'h1e});

        // --- alternation with both requesters always valid ---
        do_reset();
        req0_valid = 1; req0_data = 56'h0; req0_last = 1;
        req1_valid = 1; req1_data = 56'h1; req1_last = 1;
        slot_avail = 1;
        seq.delete();
        for (int i = 0; i < 40 && seq.size() < 4; i++) begin
            tick();
            if (ipg_valid) seq.push_back(ipg_chunk[8]);
        end
        check("b_count", seq.size(), 4);
`ifdef IPG_SCHED_STRICT_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4 && i < seq.size(); i++) begin
            check($sformatf("b_grant%0d", i), seq[i], exp_seq[i]);
        end

        // --- slot_avail toggling during a 4-chunk message ---
        do_reset();
        req0_valid = 1; req0_data = 56'hC0; req0_last = 0; slot_avail = 1;
        tick();
        got = 0;
        for (int i = 0; i < 8; i++) begin
            slot_avail = (i % 2 == 0);
            req0_last  = (i == 6);
            req0_data  = 56'hC0 + 56'(i / 2);
            #1 check($sformatf("c_ready%0d", i), req0_ready, (i % 2 == 0) && i < 7);
            tick();
            if (ipg_valid) got++;
            if (i % 2 == 1) check($sformatf("c_novld%0d", i), ipg_valid, 0);
        end
        check("c_transfers", got, 4);

        // --- owner drops valid mid-message; other requester must wait ---
        do_reset();
        req1_valid = 1; req1_data = 56'hD1; req1_last = 0; slot_avail = 1;
        tick();
        check("d_grant1", grant_id, 1);
        req0_valid = 1; req0_data = 56'hE0; req0_last = 1;
        #1 check("d_ready1", req1_ready, 1);
        tick();
        req1_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("d_r0_wait%0d", i), req0_ready, 0);
            tick();
        end
        req1_valid = 1; req1_data = 56'hD2; req1_last = 1;
        #1 check("d_r0_wait_last", req0_ready, 0);
        tick();
        check("d_last_chunk", ipg_chunk, {56'hD2, 8'h1e});
        req1_valid = 0;
        tick();
        tick();
        check("d_grant0", grant_id, 0);
        check("d_busy0", busy, 1);
        tick();
        req0_valid = 0;

        // --- overlong message cut at MAX_CHUNKS ---
        do_reset();
        req0_valid = 1; req0_data = 56'h100; req0_last = 0; slot_avail = 1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ipg_valid) n++;
            if (err_overlong) break;
            req0_data = req0_data + 56'd1;
        end
        check("e_err", err_overlong, 1);
        check("e_transfers", n, 10);
        check("e_busy_gap", busy, 1);
        #1 check("e_left_xfer", req0_ready, 0);
        req0_valid = 0;

        // --- reset in the middle of a message ---
        do_reset();
        req0_valid = 1; req0_data = 56'h5; req0_last = 1; slot_avail = 1;
        n = 0;
        for (int i = 0; i < 20 && !ipg_valid; i++) begin
            tick();
            n++;
        end
        check("f_first_msg", ipg_valid, 1);
        req0_valid = 0; req0_last = 0;
        req1_valid = 1; req1_data = 56'hF1; req1_last = 0;
        for (int i = 0; i < 20 && !(ipg_valid && grant_id); i++) tick();
        check("f_req1_chunk1", ipg_chunk, {56'hF1, 8'h1e});
        req1_data = 56'hF2;
        req0_valid = 1;
        #1 rst_n = 0;
        #1;
        check("f_rst_vld",    ipg_valid, 0);
        check("f_rst_chunk",  ipg_chunk, 0);
        check("f_rst_busy",   busy, 0);
        check("f_rst_grant",  grant_id, 0);
        check("f_rst_ready0", req0_ready, 0);
        check("f_rst_ready1", req1_ready, 0);
        tick();
        rst_n = 1;
        req0_last = 1; req1_last = 1;
        tick();
        check("f_post_grant", grant_id, 0);
        check("f_post_busy", busy, 1);

        // --- randomized traffic ---
        do_reset();
        for (int r = 0; r < 2; r++) begin
            s_len[r]  = $urandom_range(1, 12);
            s_idx[r]  = 0;
            s_data[r] = 56'({$urandom(), $urandom()});
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            hs[0] = hs0;
            hs[1] = hs1;
            if (cyc == 2000) rst_n = 0;
            if (cyc == 2001) rst_n = 1;
            for (int r = 0; r < 2; r++) begin
                if (hs[r]) begin
                    if (s_idx[r] >= s_len[r] - 1) begin
                        s_len[r] = $urandom_range(1, 12);
                        s_idx[r] = 0;
                    end else begin
                        s_idx[r]++;
                    end
                    s_data[r] = 56'({$urandom(), $urandom()});
                end
            end
            slot_avail = ($urandom_range(0, 3) != 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_data  = s_data[0];
            req0_last  = (s_idx[0] == s_len[0] - 1);
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_data  = s_data[1];
            req1_last  = (s_idx[1] == s_len[1] - 1);
        end

        idle_inputs();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
